// File: rtl/pe_mode_pipe.sv
// pe_mode_pipe: two-stage signed MAC PE, runtime IS/WS/OS dataflow, double-buffered stationary operand.
// Optional PE_SAT_EN: saturating stage-2 add and OS accumulate, plus a registered sat_hit pulse.
module pe_mode_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  stat_load,
  input  logic                  stat_swap,
  input  logic                  os_drain,
  output logic [DATA_WIDTH-1:0] in_out,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  out_valid
`ifdef PE_SAT_EN
  ,
  output logic                  sat_hit
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = PSUM_WIDTH;

  typedef enum logic [1:0] {
    M_IS   = 2'b00,
    M_WS   = 2'b01,
    M_OS   = 2'b10,
    M_IDLE = 2'b11
  } mode_e;

  logic [DW-1:0]          shadow;
  logic [DW-1:0]          active;
  logic [PW-1:0]          acc;
  logic [PW-1:0]          p1;
  logic [PW-1:0]          s1;
  logic [1:0]             m1;
  logic                   v1;
  logic signed [DW-1:0]   op_a;
  logic signed [DW-1:0]   op_b;
  logic signed [2*DW-1:0] prod;
  logic                   issue;
  logic                   os_commit;
  logic [PW-1:0]          sum2;
  logic [PW-1:0]          sum_acc;
  logic [PW-1:0]          acc_next;

  assign issue = in_valid && (mode != M_IDLE);

  always_comb begin
    op_a = in_data;
    op_b = w_data;
    unique case (mode)
      M_IS:    op_a = active;
      M_WS:    op_b = active;
      default: ;
    endcase
  end

  assign prod = op_a * op_b;

`ifdef PE_SAT_EN
  localparam logic [PW-1:0] SAT_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SAT_MIN = {1'b1, {(PW-1){1'b0}}};

  logic [PW:0] wide2;
  logic [PW:0] wide_acc;
  logic        sat2;
  logic        sat_acc;
  logic        hit;

  always_comb begin
    wide2    = {s1[PW-1], s1} + {p1[PW-1], p1};
    wide_acc = {acc[PW-1], acc} + {p1[PW-1], p1};
    sat2     = wide2[PW] != wide2[PW-1];
    sat_acc  = wide_acc[PW] != wide_acc[PW-1];
    sum2     = wide2[PW-1:0];
    sum_acc  = wide_acc[PW-1:0];
    if (sat2)
      sum2 = wide2[PW] ? SAT_MIN : SAT_MAX;
    if (sat_acc)
      sum_acc = wide_acc[PW] ? SAT_MIN : SAT_MAX;
  end

  // A drain drops any same-cycle pass-through, so only the OS commit can flag.
  assign hit = os_drain ? (os_commit && sat_acc)
                        : (v1 && (os_commit ? sat_acc : sat2));

  always_ff @(posedge clk) begin
    if (!rst_n)
      sat_hit <= 1'b0;
    else
      sat_hit <= hit;
  end
`else
  assign sum2    = s1 + p1;
  assign sum_acc = acc + p1;
`endif

  assign os_commit = v1 && (m1 == M_OS);
  assign acc_next  = os_commit ? sum_acc : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_out    <= '0;
      w_out     <= '0;
      shadow    <= '0;
      active    <= '0;
      acc       <= '0;
      p1        <= '0;
      s1        <= '0;
      m1        <= '0;
      v1        <= 1'b0;
      psum_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        in_out <= in_data;
        w_out  <= w_data;
      end
      if (stat_load)
        shadow <= (mode == M_IS) ? in_data : w_data;
      if (stat_swap)
        active <= shadow;
      v1 <= issue;
      if (issue) begin
        p1 <= PW'(prod);
        s1 <= psum_in;
        m1 <= mode;
      end
      acc <= os_drain ? '0 : acc_next;
      if (os_drain) begin
        psum_out  <= acc_next;
        out_valid <= 1'b1;
      end else begin
        out_valid <= v1;
        if (v1)
          psum_out <= os_commit ? s1 : sum2;
      end
    end
  end

endmodule

// File: tb/tb_pe_mode_pipe.sv
// tb_pe_mode_pipe: directed vector table plus randomized run against a beat-level reference model.
// Build with +define+PE_SAT_EN to exercise the saturating variant.
module tb_pe_mode_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         mode;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic signed [15:0] w_data;
  logic signed [31:0] psum_in;
  logic               stat_load;
  logic               stat_swap;
  logic               os_drain;
  logic [15:0]        in_out;
  logic [15:0]        w_out;
  logic [31:0]        psum_out;
  logic               out_valid;
`ifdef PE_SAT_EN
  logic               sat_hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_mode_pipe #(.DATA_WIDTH(16), .PSUM_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .w_data(w_data), .psum_in(psum_in),
    .stat_load(stat_load), .stat_swap(stat_swap), .os_drain(os_drain),
    .in_out(in_out), .w_out(w_out), .psum_out(psum_out),
    .out_valid(out_valid)
`ifdef PE_SAT_EN
    , .sat_hit(sat_hit)
`endif
  );

  // Reference model: stationary values, accumulator, and the one beat in flight.
  int          m_shadow, m_active, m_acc;
  bit          p_v;
  logic [1:0]  p_md;
  int          p_prod, p_ps;
  int          e_ps;
  bit          e_v, e_sat;
  logic [15:0] e_in, e_w;

  function automatic int fix(input longint x, output bit hit);
    hit = 1'b0;
`ifdef PE_SAT_EN
    if (x > 64'sd2147483647) begin
      hit = 1'b1;
      return 32'h7fffffff;
    end
    if (x < -64'sd2147483648) begin
      hit = 1'b1;
      return 32'h80000000;
    end
`endif
    return int'(x);
  endfunction

  task automatic model_edge();
    bit ha, hb;
    int accn, nsh;
    if (!rst_n) begin
      m_shadow = 0; m_active = 0; m_acc = 0; p_v = 0;
      e_ps = 0; e_v = 0; e_sat = 0; e_in = '0; e_w = '0;
      return;
    end
    ha = 0; hb = 0; accn = m_acc; e_sat = 0;
    if (p_v && p_md == 2'b10)
      accn = fix(longint'(m_acc) + longint'(p_prod), ha);
    if (os_drain) begin
      e_ps = accn; e_v = 1; m_acc = 0; e_sat = ha;
    end else begin
      m_acc = accn;
      e_v = p_v;
      if (p_v) begin
        if (p_md == 2'b10) begin
          e_ps = p_ps; e_sat = ha;
        end else begin
          e_ps = fix(longint'(p_ps) + longint'(p_prod), hb);
          e_sat = hb;
        end
      end
    end
    if (in_valid) begin
      e_in = in_data; e_w = w_data;
    end
    p_v = in_valid && (mode != 2'b11);
    if (p_v) begin
      case (mode)
        2'b00:   p_prod = m_active * int'(w_data);
        2'b01:   p_prod = int'(in_data) * m_active;
        default: p_prod = int'(in_data) * int'(w_data);
      endcase
      p_md = mode;
      p_ps = psum_in;
    end
    nsh = stat_load ? ((mode == 2'b00) ? int'(in_data) : int'(w_data)) : m_shadow;
    if (stat_swap) m_active = m_shadow;
    m_shadow = nsh;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_and_check();
    model_edge();
    @(posedge clk);
    #1;
    check("model in_out", 32'(in_out), 32'(e_in));
    check("model w_out", 32'(w_out), 32'(e_w));
    check("model out_valid", 32'(out_valid), 32'(e_v));
    check("model psum_out", psum_out, e_ps);
`ifdef PE_SAT_EN
    check("model sat_hit", 32'(sat_hit), 32'(e_sat));
`endif
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  md;
    logic        iv;
    logic [15:0] id;
    logic [15:0] wd;
    logic [31:0] ps;
    logic        ld, sw, dr;
    bit          chk;
    logic [31:0] eps;
    logic        ev;
    logic        esat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] md, input logic iv,
                              input int id, input int wd, input int ps,
                              input logic ld, input logic sw, input logic dr,
                              input bit chk, input int eps, input logic ev);
    vec_t v;
    v.rst = rst; v.md = md; v.iv = iv;
    v.id = 16'(id); v.wd = 16'(wd); v.ps = ps;
    v.ld = ld; v.sw = sw; v.dr = dr;
    v.chk = chk; v.eps = eps; v.ev = ev; v.esat = 1'b0;
    return v;
  endfunction

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      rst_n     = ($urandom_range(99) != 0);
      mode      = 2'($urandom_range(3));
      in_valid  = ($urandom_range(3) != 0);
      if ($urandom_range(1) != 0) begin
        in_data = 16'($urandom);
        w_data  = 16'($urandom);
        psum_in = 32'($urandom);
      end else begin
        in_data = 16'($signed($urandom_range(40)) - 20);
        w_data  = 16'($signed($urandom_range(40)) - 20);
        psum_in = 32'($signed($urandom_range(2000)) - 1000);
      end
      stat_load = ($urandom_range(3) == 0);
      stat_swap = ($urandom_range(5) == 0);
      os_drain  = ($urandom_range(7) == 0);
      tick_and_check();
    end
  endtask

  localparam logic [1:0] IS = 2'b00, WS = 2'b01, OS = 2'b10, ID = 2'b11;

  initial begin
    logic [31:0] ovf;
`ifdef PE_SAT_EN
    ovf = 32'h7fffffff;
`else
    ovf = 32'h80000054;
`endif
    // reset with junk on the inputs, then swap of a cleared shadow
    vecs.push_back(mk(0, IS, 1, 77, 88, 5, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, OS, 1, 77, 88, 5, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, WS, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    // WS double buffering
    vecs.push_back(mk(1, WS, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 1, 5, 0, 10, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 0, 0, 0, 0, 0, 0, 0, 1, 25, 1));
    vecs.push_back(mk(1, WS, 0, 0, 0, 0, 0, 0, 0, 1, 25, 0));
    // IS load+swap in one cycle
    vecs.push_back(mk(1, IS, 0, -2, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, IS, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, IS, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, IS, 0, 11, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, IS, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, IS, 0, 0, 0, 0, 0, 0, 0, 1, 28, 1));
    vecs.push_back(mk(1, IS, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, IS, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, IS, 0, 0, 0, 0, 0, 0, 0, 1, 44, 1));
    // OS accumulate, pass-through and drains
    vecs.push_back(mk(1, OS, 1, 2, 3, 100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OS, 1, 4, 5, 200, 0, 0, 0, 1, 100, 1));
    vecs.push_back(mk(1, OS, 1, -1, 6, 300, 0, 0, 0, 1, 200, 1));
    vecs.push_back(mk(1, OS, 0, 0, 0, 0, 0, 0, 0, 1, 300, 1));
    vecs.push_back(mk(1, OS, 0, 0, 0, 0, 0, 0, 1, 1, 20, 1));
    vecs.push_back(mk(1, OS, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, OS, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // WS overflow
    vecs.push_back(mk(1, WS, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 1, 100, 0, 32'h7ffffff0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, WS, 0, 0, 0, 0, 0, 0, 0, 1, ovf, 1));
`ifdef PE_SAT_EN
    vecs[vecs.size()-1].esat = 1'b1;
`endif
    vecs.push_back(mk(1, ID, 0, 0, 0, 0, 0, 0, 0, 1, ovf, 0));
    // mode change behind an in-flight WS beat
    vecs.push_back(mk(1, WS, 1, 3, 0, 50, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, OS, 1, 2, 2, 7, 0, 0, 0, 1, 53, 1));
    vecs.push_back(mk(1, OS, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1));
    vecs.push_back(mk(1, ID, 0, 0, 0, 0, 0, 0, 1, 1, 4, 1));
    // reset while a beat is in flight
    vecs.push_back(mk(1, OS, 1, 5, 5, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OS, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, OS, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, OS, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));

    rst_n = 0; mode = '0; in_valid = 0; in_data = '0; w_data = '0;
    psum_in = '0; stat_load = 0; stat_swap = 0; os_drain = 0;
    #1;
    tick_and_check();
    tick_and_check();
    run_random(20);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst; mode = vecs[i].md; in_valid = vecs[i].iv;
      in_data = vecs[i].id; w_data = vecs[i].wd; psum_in = vecs[i].ps;
      stat_load = vecs[i].ld; stat_swap = vecs[i].sw; os_drain = vecs[i].dr;
      tick_and_check();
      if (vecs[i].chk) begin
        check($sformatf("vec%0d psum_out", i), psum_out, vecs[i].eps);
        check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
`ifdef PE_SAT_EN
        check($sformatf("vec%0d sat_hit", i), 32'(sat_hit), 32'(vecs[i].esat));
`endif
      end
    end

    run_random(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mode_pipe.md
Name: pe_mode_pipe

Overview:
- Second-generation processing element (PE) for the systolic array.
- Performs a signed multiply-accumulate (MAC) with a runtime-selectable dataflow: input-stationary (IS), weight-stationary (WS) or output-stationary (OS).
- Two-stage pipeline with a valid bit.
- Stationary operand is double-buffered (shadow/active), so the next tile's stationary value preloads while the current tile streams.
- One instance per array cell; streaming operands are forwarded to the neighbour PEs.

Parameters:
- DATA_WIDTH, 16, signed width of both operands (input and weight).
- PSUM_WIDTH, 32, signed partial-sum and accumulator width; must be >= 2*DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  2  dataflow select: 00=IS, 01=WS, 10=OS, 11=idle.
- in_valid  in  1  operand beat valid.
- in_data  in  DATA_WIDTH  streaming/loadable input activation.
- w_data  in  DATA_WIDTH  streaming/loadable weight.
- psum_in  in  PSUM_WIDTH  partial sum from upstream PE.
- stat_load  in  1  load shadow stationary register.
- stat_swap  in  1  copy shadow into active stationary register.
- os_drain  in  1  OS mode: emit accumulator and clear it.
- in_out  out  DATA_WIDTH  registered in_data forwarded to neighbour.
- w_out  out  DATA_WIDTH  registered w_data forwarded to neighbour.
- psum_out  out  PSUM_WIDTH  result / forwarded partial sum.
- out_valid  out  1  psum_out valid.

Behaviour:
- Reset (rst_n low at a clk edge) clears everything, including in the middle of an operation:
  - registers: shadow, active, acc and all pipeline registers go to 0;
  - outputs: in_out, w_out, psum_out and out_valid go to 0;
  - in-flight beats are discarded.
- Forwarding: when in_valid=1, in_out<=in_data and w_out<=w_data (latency 1). Otherwise both hold their values. Forwarding is the same in every mode.
- Stationary load: stat_load=1 loads shadow from in_data when mode=IS, otherwise from w_data. stat_load does not depend on in_valid.
- Stationary swap: stat_swap=1 sets active<=shadow.
- Load and swap in the same cycle: active takes the OLD shadow value; shadow takes the new value.
- Stage 1 (only when in_valid=1 and mode!=11):
  - Operand selection:
    - IS: a=active, b=w_data.
    - WS: a=in_data, b=active.
    - OS: a=in_data, b=w_data.
  - Register p1=a*b, sign-extended to PSUM_WIDTH.
  - Register s1=psum_in.
  - Register m1=mode, so in-flight beats complete in the mode they were issued in.
  - Set v1=1; otherwise v1<=0.
- Stage 2, IS/WS beat: psum_out<=s1+p1, out_valid<=v1. End-to-end latency is 2 cycles.
- Stage 2, OS beat:
  - acc<=acc+p1.
  - psum_out<=s1 (pass-through of the upstream chain), out_valid<=v1.
- Drain (os_drain=1, effective in any mode):
  - psum_out<=acc_next, where acc_next = acc plus any OS p1 committing in the same cycle;
  - out_valid<=1; acc<=0.
  - Drain wins over a same-cycle pass-through beat, which is dropped; the controller must not overlap them.
- When out_valid is 0, psum_out holds its last value.
- Arithmetic: two's-complement; sums wrap modulo 2^PSUM_WIDTH.
- mode=11: no new beats enter the pipeline. In-flight beats, forwarding, load/swap and drain still operate.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined:
  - The stage-2 add and the OS accumulate saturate to the signed PSUM_WIDTH limits (0x7FFFFFFF / 0x80000000 at default width).
  - Extra output port sat_hit (1 bit, registered, reset 0) pulses 1 for one cycle with each saturated result.
- Undefined: wrap-around arithmetic; no sat_hit port.

Test Plan:
- Reset: drive random inputs, then hold rst_n=0 for 2 cycles -> all outputs 0. Then set stat_swap=1 with in_valid=0 -> active=0, confirmed by a WS beat with in_data=9, psum_in=0 giving psum_out=0.
- WS with double buffering:
  - stat_load with w_data=3, then stat_swap.
  - Beat in_data=5, psum_in=10 -> in_out=5 at +1 cycle; psum_out=25, out_valid=1 at +2 cycles.
- IS load+swap same cycle:
  - Setup: active=-2, shadow=7.
  - Cycle with stat_load=1 (in_data=11) and stat_swap=1 -> active=7, shadow=11.
  - Beat w_data=4, psum_in=0 -> psum_out=28.
  - A further swap followed by the same beat -> 44.
- OS:
  - Beats (2,3), (4,5), (-1,6) with psum_in=100,200,300 -> pass-through psum_out of 100, 200, 300.
  - os_drain -> psum_out=20, acc=0.
  - Second os_drain -> psum_out=0.
- Overflow: WS with active=1, in_data=100, psum_in=0x7FFFFFF0 -> psum_out=0x80000054. With PE_SAT_EN -> 0x7FFFFFFF and sat_hit=1 for one cycle.
- Mode change and mid-operation reset:
  - WS beat, then next cycle mode=OS -> the WS beat still yields s1+p1.
  - rst_n=0 while v1=1 -> out_valid stays 0 and acc=0.
